// File: rtl/mul8_pkg.sv
// Shared definitions for the sequential 8x8 shift-and-add multiplier.
package mul8_pkg;
    localparam int W     = 8;
    localparam int RW    = 2 * W;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul8_state_t;
endpackage

// File: rtl/mul8_pp_row.sv
// One partial-product row: b_r gated by a single multiplicand bit, placed at its weight.
module mul8_pp_row
    import mul8_pkg::*;
(
    input  logic [W-1:0]     b_r,
    input  logic             a_i,
    input  logic [CNT_W-1:0] idx,
    output logic [RW-1:0]    row
);
    logic [RW-1:0] row_ext;

    assign row_ext = {{(RW - W){1'b0}}, b_r & {W{a_i}}};
    assign row     = row_ext << idx;
endmodule

// File: rtl/mul8_seq.sv
// Sequential 8x8 unsigned multiplier: one partial-product row per cycle into a 16-bit accumulator.
module mul8_seq
    import mul8_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic          ready,
    output logic          busy,
    output logic          done,
    output logic [RW-1:0] y
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    mul8_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [RW-1:0]    acc;
    logic [RW-1:0]    row;
    logic [RW-1:0]    sum;
    logic [W-1:0]     a_r;
    logic [W-1:0]     b_r;
    logic             accept;

    mul8_pp_row u_pp_row (
        .b_r (b_r),
        .a_i (a_r[cnt]),
        .idx (cnt),
        .row (row)
    );

    assign sum = acc + row;

    // abort outranks start everywhere; DONE falls back to IDLE unless a new request arrives
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (abort)
                    state_nxt = IDLE;
                else if (cnt == CNT_LAST)
                    state_nxt = DONE;
            end
            DONE: begin
                if (start && !abort) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ready = (state == IDLE) || (state == DONE);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            a_r   <= '0;
            b_r   <= '0;
            y     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_r <= a;
                b_r <= b;
                acc <= '0;
                cnt <= '0;
            end else if (state == RUN && !abort) begin
                acc <= sum;
                cnt <= cnt + 1'b1;
                // last row lands straight in y so the product is visible with done
                if (cnt == CNT_LAST)
                    y <= sum;
            end
        end
    end
endmodule

// File: tb/tb_mul8_seq.sv
// Directed self-checking bench for mul8_seq.
module tb_mul8_seq;
    import mul8_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          ready;
    logic          busy;
    logic          done;
    logic [RW-1:0] y;

    int errors = 0;
    int checks = 0;

    mul8_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .a     (a),
        .b     (b),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .y     (y)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; abort = 1'b0; a = '0; b = '0;
        repeat (2) tick;
        checks++;
        if ({ready, busy, done} !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags got rbd=%b exp=100", {ready, busy, done});
        end
        checks++;
        if (y !== 16'd0) begin
            errors++;
            $display("FAIL reset_y got=%0d exp=0", y);
        end
        rst = 1'b0;
        tick;
    endtask

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic [15:0] exp, input string name);
        a = ta; b = tb_v; start = 1'b1;
        tick;
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({ready, busy, done} !== 3'b010) begin
                errors++;
                $display("FAIL %s_busy_E%0d got rbd=%b exp=010", name, i, {ready, busy, done});
            end
            tick;
        end
        checks++;
        if ({ready, busy, done} !== 3'b101) begin
            errors++;
            $display("FAIL %s_done_E8 got rbd=%b exp=101", name, {ready, busy, done});
        end
        checks++;
        if (y !== exp) begin
            errors++;
            $display("FAIL %s_y got=%0d exp=%0d", name, y, exp);
        end
        tick;
        checks++;
        if ({ready, busy, done} !== 3'b100) begin
            errors++;
            $display("FAIL %s_idle_E9 got rbd=%b exp=100", name, {ready, busy, done});
        end
    endtask

    task automatic test_products;
        run_op(8'd13,  8'd11,  16'd143,   "p13x11");
        run_op(8'd255, 8'd255, 16'd65025, "p255x255");
        run_op(8'd0,   8'd200, 16'd0,     "p0x200");
        run_op(8'd1,   8'd1,   16'd1,     "p1x1");
        run_op(8'd128, 8'd2,   16'd256,   "p128x2");
    endtask

    task automatic test_start_while_busy;
        a = 8'd12; b = 8'd10; start = 1'b1;
        tick;                       // E0
        start = 1'b0;
        repeat (2) tick;            // E2
        a = 8'd7; b = 8'd7; start = 1'b1;
        tick;                       // E3
        start = 1'b0;
        repeat (4) tick;            // E7
        checks++;
        if ({ready, busy, done} !== 3'b010) begin
            errors++;
            $display("FAIL ign_busy_E7 got rbd=%b exp=010", {ready, busy, done});
        end
        tick;                       // E8
        checks++;
        if (done !== 1'b1 || y !== 16'd120) begin
            errors++;
            $display("FAIL ign_result got done=%b y=%0d exp done=1 y=120", done, y);
        end
        for (int i = 0; i < 10; i++) begin
            tick;
            checks++;
            if ({ready, busy, done} !== 3'b100) begin
                errors++;
                $display("FAIL ign_no_second_done_%0d got rbd=%b exp=100", i, {ready, busy, done});
            end
        end
    endtask

    task automatic test_back_to_back;
        a = 8'd6; b = 8'd7; start = 1'b1;
        tick;                       // E0
        a = 8'd9; b = 8'd9;
        for (int i = 1; i < 8; i++) begin
            tick;
            checks++;
            if ({ready, busy, done} !== 3'b010) begin
                errors++;
                $display("FAIL b2b_first_busy_E%0d got rbd=%b exp=010", i, {ready, busy, done});
            end
        end
        tick;                       // E8
        checks++;
        if (done !== 1'b1 || y !== 16'd42) begin
            errors++;
            $display("FAIL b2b_first got done=%b y=%0d exp done=1 y=42", done, y);
        end
        tick;                       // E9: accepted straight from DONE
        start = 1'b0;
        for (int i = 9; i < 17; i++) begin
            checks++;
            if ({ready, busy, done} !== 3'b010) begin
                errors++;
                $display("FAIL b2b_second_busy_E%0d got rbd=%b exp=010", i, {ready, busy, done});
            end
            tick;
        end
        checks++;                   // E17
        if (done !== 1'b1 || y !== 16'd81) begin
            errors++;
            $display("FAIL b2b_second got done=%b y=%0d exp done=1 y=81", done, y);
        end
        tick;
    endtask

    task automatic test_abort;
        run_op(8'd3, 8'd5, 16'd15, "p3x5");
        a = 8'd100; b = 8'd100; start = 1'b1;
        tick;                       // E0
        start = 1'b0;
        repeat (4) tick;            // E4
        abort = 1'b1;
        tick;                       // E5
        abort = 1'b0;
        checks++;
        if ({ready, busy, done} !== 3'b100) begin
            errors++;
            $display("FAIL abort_idle got rbd=%b exp=100", {ready, busy, done});
        end
        for (int i = 0; i < 8; i++) begin
            tick;
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_done_%0d got done=%b exp=0", i, done);
            end
        end
        checks++;
        if (y !== 16'd15) begin
            errors++;
            $display("FAIL abort_y_held got=%0d exp=15", y);
        end
        a = 8'd2; b = 8'd2; start = 1'b1; abort = 1'b1;
        tick;
        checks++;
        if ({ready, busy, done} !== 3'b100) begin
            errors++;
            $display("FAIL abort_start_idle got rbd=%b exp=100", {ready, busy, done});
        end
        start = 1'b0; abort = 1'b0;
        repeat (9) tick;
        checks++;
        if (done !== 1'b0 || y !== 16'd15) begin
            errors++;
            $display("FAIL abort_start_no_op got done=%b y=%0d exp done=0 y=15", done, y);
        end
    endtask

    task automatic test_reset_mid_run;
        a = 8'd20; b = 8'd30; start = 1'b1;
        tick;                       // E0
        start = 1'b0;
        repeat (5) tick;            // E5
        rst = 1'b1;
        #1;
        checks++;
        if ({ready, busy, done} !== 3'b100 || y !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid_run got rbd=%b y=%0d exp rbd=100 y=0", {ready, busy, done}, y);
        end
        #2;
        rst = 1'b0;
        a = 8'd20; b = 8'd30; start = 1'b1;
        tick;                       // E0 after release
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_first_edge_accept got busy=%b exp=1", busy);
        end
        repeat (7) tick;            // E7
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL rst_early_done got done=%b exp=0", done);
        end
        tick;                       // E8
        checks++;
        if (done !== 1'b1 || y !== 16'd600) begin
            errors++;
            $display("FAIL rst_rerun got done=%b y=%0d exp done=1 y=600", done, y);
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_products;
        test_start_while_busy;
        test_back_to_back;
        test_abort;
        test_reset_mid_run;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
